// File: rtl/upsampler_pkg.sv
// upsampler_pkg: mode encodings, default sizes and phase-width helper for the upsampler
package upsampler_pkg;
  localparam logic MODE_ZERO = 1'b0;
  localparam logic MODE_HOLD = 1'b1;
  localparam int W_DEF = 18;
  localparam int CH_DEF = 2;
  localparam int L_DEF = 4;
  function automatic int phase_w(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction
endpackage

// File: rtl/upsampler_lane.sv
// upsampler_lane: per-channel hold register and registered output mux
module upsampler_lane #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sam_en,
  input  logic         int_en,
  input  logic         pass,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic [W-1:0] hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      y    <= '0;
    end else begin
      if (sam_en) hold <= x;
      if (int_en) y <= pass ? (sam_en ? x : hold) : '0;
    end
  end
endmodule

// File: rtl/upsampler_ln.sv
// upsampler_ln: L-times zero-stuff upsampler; define UPSAMPLER_HOLD_EN to add
// a mode-selectable sample-and-hold option.
module upsampler_ln
  import upsampler_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CH = CH_DEF,
  parameter int L  = L_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sam_en,
  input  logic                  int_en,
  input  logic                  mode,
  input  logic                  err_clr,
  input  logic [CH*W-1:0]       x_in,
  output logic [CH*W-1:0]       y_out,
  output logic                  y_valid,
  output logic [phase_w(L)-1:0] phase,
  output logic                  err_over,
  output logic                  err_under
);
  localparam int PW = phase_w(L);
  localparam int CW = $clog2(L + 1);
  // cnt counts outputs emitted since the last sample, saturating at L
  logic [CW-1:0] cnt, cnt_eff;
  logic          armed, full, pass;
  logic [PW-1:0] ph_now;
`ifndef UPSAMPLER_HOLD_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif
  always_comb begin
    cnt_eff = sam_en ? '0 : cnt;
    full    = cnt_eff == CW'(L);
    ph_now  = full ? PW'(L - 1) : PW'(cnt_eff);
`ifdef UPSAMPLER_HOLD_EN
    pass    = (ph_now == '0) || (mode == MODE_HOLD);
`else
    pass    = ph_now == '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      armed     <= 1'b0;
      y_valid   <= 1'b0;
      phase     <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      y_valid   <= int_en;
      if (int_en) phase <= ph_now;
      if (sam_en) armed <= 1'b1;
      cnt       <= (int_en && !full) ? cnt_eff + 1'b1 : cnt_eff;
      err_over  <= (sam_en && armed && cnt < CW'(L)) || (err_over && !err_clr);
      err_under <= (int_en && full && armed) || (err_under && !err_clr);
    end
  end
  for (genvar c = 0; c < CH; c++) begin : g_lane
    upsampler_lane #(.W(W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .sam_en (sam_en),
      .int_en (int_en),
      .pass   (pass),
      .x      (x_in[c*W +: W]),
      .y      (y_out[c*W +: W])
    );
  end
endmodule

// File: tb/tb_upsampler_ln.sv
// tb_upsampler_ln: scoreboard bench for upsampler_ln (directed + random vs behavioural model)
module tb_upsampler_ln;
  localparam int W = 18;
  localparam int CH = 2;
  localparam int L = 4;
  localparam int PW = 2;
`ifdef UPSAMPLER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, sam_en, int_en, mode, err_clr;
  logic [CH*W-1:0] x_in, y_out;
  logic y_valid, err_over, err_under;
  logic [PW-1:0] phase;
  upsampler_ln #(.W(W), .CH(CH), .L(L)) dut (
    .clk(clk), .reset(reset), .sam_en(sam_en), .int_en(int_en), .mode(mode),
    .err_clr(err_clr), .x_in(x_in), .y_out(y_out), .y_valid(y_valid),
    .phase(phase), .err_over(err_over), .err_under(err_under)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [CH*W-1:0] y;
    logic [PW-1:0]   ph;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hold[CH];
  bit m_armed, m_eo, m_eu;
  int m_emit;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < CH; c++) m_hold[c] = '0;
    m_armed = 0; m_eo = 0; m_eu = 0; m_emit = 0;
  endtask
  task automatic step(input bit se, input bit ie, input bit md, input bit ec, input logic [CH*W-1:0] x);
    bit eo_set, eu_set;
    int ph;
    exp_t e;
    eo_set = 0; eu_set = 0;
    sam_en = se; int_en = ie; mode = md; err_clr = ec; x_in = x;
    if (se) begin
      eo_set = m_armed && m_emit < L;
      for (int c = 0; c < CH; c++) m_hold[c] = x[c*W +: W];
      m_armed = 1; m_emit = 0;
    end
    if (ie) begin
      if (m_emit >= L) begin
        ph = L - 1; eu_set = m_armed;
      end else begin
        ph = m_emit; m_emit++;
      end
      e.ph = PW'(ph);
      for (int c = 0; c < CH; c++) e.y[c*W +: W] = (ph == 0 || (HOLD && md)) ? m_hold[c] : '0;
      q.push_back(e);
    end
    m_eo = eo_set || (m_eo && !ec);
    m_eu = eu_set || (m_eu && !ec);
    @(posedge clk); #1;
    chk("err_over", 64'(err_over), 64'(m_eo));
    chk("err_under", 64'(err_under), 64'(m_eu));
    chk("y_valid", 64'(y_valid), 64'(ie));
  endtask
  task automatic do_reset();
    reset = 1; sam_en = 0; int_en = 0; err_clr = 0;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    chk("rst_y_out", 64'(y_out), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_y_valid", 64'(y_valid), 64'd0);
    chk("rst_err", {62'd0, err_over, err_under}, 64'd0);
  endtask
  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("y_out", 64'(y_out), 64'(e.y));
        chk("phase", 64'(phase), 64'(e.ph));
      end
    end
  end
  initial begin
    logic [CH*W-1:0] z;
    z = '0;
    reset = 1; sam_en = 0; int_en = 0; mode = 0; err_clr = 0; x_in = '0;
    model_clear();
    do_reset();
    // zero-stuff then underrun on the fifth int_en
    step(1, 0, 0, 0, {18'(-5), 18'd100});
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, z);
    step(0, 0, 0, 1, z);
    // hold mode
    step(1, 0, 1, 0, {18'd0, 18'(-131072)});
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, z);
    // overrun, recovery at phase 0, then clear
    step(1, 0, 0, 0, {18'd3, 18'd11});
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    step(1, 0, 0, 0, {18'd4, 18'd22});
    step(0, 1, 0, 0, z);
    step(0, 0, 0, 1, z);
    // coincident sam_en and int_en
    step(1, 1, 0, 0, {18'd0, 18'd7});
    step(0, 0, 0, 0, z);
    // reset mid-sequence
    step(1, 0, 0, 0, {18'd9, 18'd8});
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    do_reset();
    step(0, 1, 0, 0, z);
    step(0, 0, 0, 0, z);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 1'($urandom),
           $urandom_range(0, 19) == 0, {18'($urandom), 18'($urandom)});
    end
    step(0, 0, 0, 0, z);
    step(0, 0, 0, 0, z);
    chk("drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/upsampler_ln.md
UPSAMPLER_LN -- requirements
Module: upsampler_ln

Interface
REQ-001 The block SHALL have parameter W, default 18, meaning signed sample width per channel.
REQ-002 The block SHALL have parameter CH, default 2, meaning number of parallel channels.
REQ-003 The block SHALL have parameter L, default 4, meaning upsampling factor (range 2..16).
REQ-004 The block SHALL have port clk, input, 1, meaning system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port sam_en, input, 1, meaning input-rate strobe; one clk-wide pulse per input sample.
REQ-007 The block SHALL have port int_en, input, 1, meaning output-rate strobe; one clk-wide pulse per output sample.
REQ-008 The block SHALL have port mode, input, 1, meaning 0 = zero-stuff, 1 = sample-and-hold.
REQ-009 The block SHALL have port err_clr, input, 1, meaning clears sticky error flags.
REQ-010 The block SHALL have port x_in, input, CH*W, meaning packed signed samples; channel c at bits [c*W +: W].
REQ-011 The block SHALL have port y_out, output, CH*W, meaning packed signed output samples, same packing as x_in.
REQ-012 The block SHALL have port y_valid, output, 1, meaning one-cycle pulse marking a new y_out.
REQ-013 The block SHALL have port phase, output, clog2(L), meaning phase index of the current y_out.
REQ-014 The block SHALL have port err_over, output, 1, meaning sticky flag: new sample arrived before L outputs were emitted.
REQ-015 The block SHALL have port err_under, output, 1, meaning sticky flag: more than L int_en since the last sample.

Function
REQ-016 On sam_en, the block SHALL capture all CH channels of x_in into hold registers and arm phase 0.
REQ-017 On int_en, the block SHALL register y_out one clk later with y_valid=1 for exactly that cycle; latency 1 clk.
- Phase 0 emits the held sample.
- Phases 1..L-1 emit 0 (mode=0) or the held sample (mode=1).
REQ-018 After each int_en, the phase counter SHALL advance by 1.
- After phase L-1, the next int_en without a new sam_en sets err_under.
- In that case the counter saturates at L-1 and emits 0 (mode=0) or the held sample (mode=1).
REQ-019 If sam_en arrives while the phase counter is armed and fewer than L outputs have been emitted, the block SHALL set err_over and restart at phase 0 with the new sample.
REQ-020 If sam_en and int_en coincide in the same cycle, the block SHALL use the newly captured x_in for the phase-0 output.
REQ-021 The block SHALL not apply width change or gain scaling: each output lane is bit-identical to its held input lane or exactly 0.
REQ-022 Between int_en pulses, y_out, phase and y_valid SHALL hold their values; y_valid stays 0.
REQ-023 A change on mode SHALL take effect on the next int_en.
REQ-024 err_clr SHALL clear both error flags; if an error event occurs in the same cycle, the set wins.
REQ-025 Before the first sam_en after reset, int_en SHALL emit zeros with y_valid=1 and SHALL NOT set err_under.

Reset
REQ-026 On reset, the block SHALL clear y_out, hold registers, y_valid, phase, err_over, err_under and the armed state to 0.
REQ-027 Reset SHALL override sam_en, int_en and err_clr in the same cycle; a sequence in progress is abandoned.

Configuration
REQ-028 With macro UPSAMPLER_HOLD_EN defined, the mode input SHALL select between zero-stuff and sample-and-hold as in REQ-017.
REQ-029 Without UPSAMPLER_HOLD_EN, mode SHALL be ignored, the block SHALL always zero-stuff, and no hold-mux logic is synthesized.

Structure
REQ-030 A shared package upsampler_pkg SHALL hold:
- the mode encoding constants (MODE_ZERO, MODE_HOLD);
- the phase-width function;
- the default W, CH and L constants.
REQ-031 Per-channel hold and output muxing SHALL be a sub-module upsampler_lane, instantiated CH times.
REQ-032 The phase counter, armed state and error logic SHALL be shared in the top level.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Zero-stuff: L=4, mode=0, x_in ch0=100, ch1=-5, then 4 int_en -> y ch0: 100,0,0,0; ch1: -5,0,0,0; phase 0,1,2,3; no errors.
- Hold: L=4, mode=1 (macro on), x_in ch0=-131072 -> 4 outputs all -131072; with macro off -> -131072,0,0,0.
- Underrun: 5 int_en after one sam_en -> err_under=1 on the 5th; 5th output 0 (mode=0); phase stays 3.
- Overrun and clear: sam_en after 2 int_en -> err_over=1, next output is the new sample at phase 0; err_clr pulse -> err_over=0.
- Coincident: sam_en and int_en in the same cycle with x_in ch0=7 -> next cycle y ch0=7, y_valid=1, phase 0.
- Reset mid-sequence: reset after phase 1 -> all outputs 0 the following cycle; the next int_en without sam_en -> y=0 and no err_under.
